// File: rtl/dso100fb_apb_master.sv
// dso100fb_apb_master: single-outstanding APB3 requester with valid/ready request and response channels.
// Define DSO100FB_APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module dso100fb_apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_write_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic        pwrite_q, pwrite_d, err_q, err_d;
`ifdef DSO100FB_APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef DSO100FB_APB_TIMEOUT_EN
    cnt_d    = (state_q == ACCESS) ? cnt_q + CW'(1) : '0;
`endif
    case (state_q)
      IDLE: if (req_valid_i) begin
        paddr_d  = {req_addr_i[31:2], 2'b00};
        pwdata_d = req_wdata_i;
        pwrite_d = req_write_i;
        state_d  = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (pready_i) begin
        err_d   = pslverr_i;
        rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
        state_d = RESP;
      end
`ifdef DSO100FB_APB_TIMEOUT_EN
      // PREADY in the limit cycle takes priority over the abort
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = RESP;
      end
`endif
      default: if (rsp_ready_i) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef DSO100FB_APB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef DSO100FB_APB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign req_ready_o = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign psel_o      = state_q == SETUP || state_q == ACCESS;
  assign penable_o   = state_q == ACCESS;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pwrite_o    = pwrite_q;
endmodule

// File: tb/tb_dso100fb_apb_master.sv
// tb_dso100fb_apb_master: scoreboard bench for the APB requester with a programmable-wait APB slave model.
module tb_dso100fb_apb_master;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_write = 0, rsp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_err, busy, psel, penable, pwrite, pready;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic [31:0] prdata_cfg = 0;
  logic        slverr_cfg = 0;
  int          waits_cfg = 0, acc_cnt = 0;
  int          n_tests = 0, n_fail = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  dso100fb_apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_write_i(req_write),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .prdata_i(prdata_cfg), .pready_i(pready), .pslverr_i(slverr_cfg)
  );

  // slave holds PREADY low for waits_cfg ACCESS cycles
  always @(posedge clk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
  assign pready = acc_cnt >= waits_cfg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && rsp_valid && rsp_ready) begin
    if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
    else begin
      logic [32:0] e;
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, e[32:1]);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, e[0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] wd, input logic w);
    req_addr = a; req_wdata = wd; req_write = w; req_valid = 1;
  endtask

  // issues one request and follows it to the response; exp_en is the expected ACCESS length
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic w, input int waits,
                      input logic [31:0] rd, input logic se, input int exp_en,
                      input logic [31:0] exp_rd, input logic exp_err);
    int cyc, en;
    waits_cfg = waits; prdata_cfg = rd; slverr_cfg = se;
    drive_req(a, wd, w);
    sb.push_back({exp_rd, exp_err});
    @(negedge clk);
    chk("acc_ready", {31'b0, req_ready}, 1);
    tick();
    req_valid = 0;
    cyc = 1; en = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      if (cyc == 1) chk("setup_penable", {31'b0, penable}, 0);
      if (!psel || cyc > 300) begin
        chk("psel_held", {31'b0, psel}, 1);
        break;
      end
      if (paddr !== (a & ~32'h3) || pwdata !== wd || pwrite !== w) begin
        chk("paddr_stable", paddr, a & ~32'h3);
        chk("pwdata_stable", pwdata, wd);
      end
      en += int'(penable);
      cyc++;
      tick();
    end
    chk("latency", cyc, 2 + exp_en);
    chk("access_len", en, exp_en);
    chk("rsp_psel", {31'b0, psel}, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d, r;
    logic        w, e;
    int          wt, en;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_apb", {28'b0, psel, penable, pwrite, 1'b0}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    tick();
    rst_n = 1;
    tick();
    xfer(32'h14, 32'h1E00, 1, 0, 32'hCAFE_F00D, 0, 1, 0, 0);
    chk("idle_paddr_kept", paddr, 32'h14);
    xfer(32'h16, 0, 0, 3, 32'hDEAD_BEEF, 0, 4, 32'hDEAD_BEEF, 0);
    xfer(32'h20, 0, 0, 0, 32'h1234_5678, 1, 1, 0, 1);
    xfer(32'h24, 32'h55AA, 1, 1, 32'h1234_5678, 1, 2, 0, 1);
    for (int i = 0; i < 6; i++) begin
      a = $urandom; d = $urandom; r = $urandom; w = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) == 0); wt = $urandom_range(0, 3);
      xfer(a, d, w, wt, r, e, wt + 1, (w || e) ? 32'h0 : r, e);
    end
    // response backpressure with a second request held
    rsp_ready = 0;
    waits_cfg = 0; prdata_cfg = 32'hAAAA_5555; slverr_cfg = 0;
    drive_req(32'h40, 0, 0);
    sb.push_back({32'hAAAA_5555, 1'b0});
    tick();
    drive_req(32'h44, 32'h77, 1);
    sb.push_back({32'h0, 1'b0});
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 1);
      chk("bp_req_ready", {31'b0, req_ready}, 0);
      chk("bp_psel", {31'b0, psel}, 0);
      chk("bp_rdata_hold", rsp_rdata, 32'hAAAA_5555);
      tick();
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("consume_req_ready", {31'b0, req_ready}, 0);
    tick();
    @(negedge clk);
    chk("idle_req_ready", {31'b0, req_ready}, 1);
    chk("idle_psel", {31'b0, psel}, 0);
    tick();
    req_valid = 0;
    @(negedge clk);
    chk("second_psel", {31'b0, psel}, 1);
    chk("second_paddr", paddr, 32'h44);
    en = 0;
    while (!rsp_valid && en < 20) begin
      tick(); @(negedge clk); en++;
    end
    chk("second_rsp", {31'b0, rsp_valid}, 1);
    tick();
`ifdef DSO100FB_APB_TIMEOUT_EN
    xfer(32'h50, 0, 0, 100000, 32'h1111_2222, 0, 4, 0, 1);
`endif
    // stuck PREADY, then reset in the middle of ACCESS
    waits_cfg = 100000;
    drive_req(32'h60, 0, 0);
    tick();
    req_valid = 0;
    en = 0;
`ifdef DSO100FB_APB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
`else
    for (int i = 0; i < 110; i++) begin
`endif
      @(negedge clk);
      en += int'(penable);
      tick();
    end
`ifdef DSO100FB_APB_TIMEOUT_EN
    chk("pre_reset_access", en, 2);
`else
    chk("stuck_access_100", {31'b0, en >= 100}, 1);
`endif
    chk("pre_reset_penable", {31'b0, penable}, 1);
    rst_n = 0;
    #1;
    chk("async_psel", {31'b0, psel}, 0);
    chk("async_penable", {31'b0, penable}, 0);
    chk("async_rsp_valid", {31'b0, rsp_valid}, 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 1);
    chk("post_rst_busy", {31'b0, busy}, 0);
    tick();
    xfer(32'h1C, 0, 0, 0, 32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D, 0);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dso100fb_apb_master.md
# dso100fb_apb_master

APB3 requester that turns single register-access requests into APB setup/access transfers. It sits between a control source and the framebuffer register slave. Typical control sources are a boot-time configuration sequencer or a debug bridge. It issues one transfer at a time, honours PREADY wait states and returns read data plus an error flag through a valid/ready response channel. An optional timeout guard turns a hung PREADY into an error response.

## Interface
- TIMEOUT_CYCLES, 255: maximum ACCESS-phase cycles before abort; legal range 1..65535; only used with DSO100FB_APB_TIMEOUT_EN
- CLK  in  1  clock; all logic on rising edge
- RST_N  in  1  reset; asynchronous, active-low
- REQ_VALID  in  1  request present
- REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  write data
- REQ_WRITE  in  1  1 = write, 0 = read
- RSP_VALID  out  1  response present
- RSP_READY  in  1  response consumed when RSP_VALID & RSP_READY
- RSP_RDATA  out  32  read data; 0 for writes and errors
- RSP_ERR  out  1  PSLVERR seen, or timeout
- BUSY  out  1  state != IDLE
- PADDR  out  32  APB address, bits [1:0] forced 0
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID: latch ADDR (with [1:0] zeroed), WDATA and WRITE into PADDR/PWDATA/PWRITE, then go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0, for exactly one cycle.
  - Then go to ACCESS, clearing the timeout counter.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - If PREADY=1: capture RSP_ERR=PSLVERR. Capture RSP_RDATA=PRDATA when the transfer is a read and PSLVERR=0, else 0. Then go to RESP.
  - Otherwise increment the counter and stay.
- RESP:
  - PSEL=PENABLE=0, RSP_VALID=1. RSP_RDATA and RSP_ERR are held stable.
  - When RSP_READY=1, go to IDLE.
- PADDR, PWDATA and PWRITE:
  - Change only on request acceptance.
  - Stable from SETUP through the end of ACCESS.
  - Retain their last values while idle.
- REQ_READY is 0 in every state except IDLE. At most one transfer is outstanding.
- A request is never accepted in the cycle a response is consumed. Acceptance only happens once the FSM is in IDLE.
- PSLVERR is sampled only in the ACCESS cycle with PREADY=1.

## Timing
- Reset values:
  - State IDLE, so REQ_READY=1.
  - RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, BUSY=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- Cycle numbering, with the request accepted on cycle 0:
  - SETUP on cycle 1.
  - First ACCESS on cycle 2.
  - With PREADY=1 on cycle 2, RSP_VALID=1 on cycle 3.
- Each PREADY=0 cycle in ACCESS adds one cycle of latency.
- Minimum request-to-request spacing is 4 cycles with RSP_READY tied high.
- RSP_READY held low: RESP persists indefinitely and APB stays idle.
- Asserting RST_N low mid-transfer:
  - Immediately forces reset values, so PSEL drops without completing.
  - The pending response is discarded.
- All outputs are registered or decoded directly from state; there is no combinational path from any input to any output.

## Configuration
- DSO100FB_APB_TIMEOUT_EN defined:
  - ACCESS counter width is ceil(log2(TIMEOUT_CYCLES+1)).
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0, abort: go to RESP with RSP_ERR=1 and RSP_RDATA=0.
  - PSEL and PENABLE drop in the next cycle.
  - A PREADY=1 arriving in the same cycle the limit is reached wins, and the transfer completes normally.
- DSO100FB_APB_TIMEOUT_EN undefined:
  - No counter is compiled and TIMEOUT_CYCLES is ignored.
  - ACCESS waits for PREADY forever.

## Test plan
- Write, zero wait:
  - Stimulus: REQ ADDR=0x0000_0014, WDATA=0x0000_1E00, WRITE=1; PREADY tied 1.
  - Response: PSEL on cycles 1–2, PENABLE on cycle 2, PADDR=0x14 and PWDATA stable over both; RSP_VALID on cycle 3 with RDATA=0, ERR=0.
- Read with wait states:
  - Stimulus: REQ ADDR=0x0000_0016; PREADY=0 for 3 ACCESS cycles, then 1 with PRDATA=0xDEAD_BEEF.
  - Response: PADDR=0x14; ACCESS lasts 4 cycles; RSP_VALID on cycle 6 with RDATA=0xDEAD_BEEF.
- Slave error on read:
  - Stimulus: PSLVERR=1 with PREADY=1, PRDATA=0x1234_5678.
  - Response: RSP_ERR=1, RSP_RDATA=0.
- Response backpressure:
  - Stimulus: RSP_READY=0 for 5 cycles while a second REQ_VALID is held.
  - Response: REQ_READY=0 and PSEL=0 throughout; the second request is accepted in the first IDLE cycle after the handshake.
- Timeout, built with DSO100FB_APB_TIMEOUT_EN and TIMEOUT_CYCLES=4:
  - Stimulus: PREADY stuck 0.
  - Response: PENABLE high for exactly 4 cycles, then RSP_ERR=1. Without the macro, PENABLE stays high for at least 100 cycles.
- Reset mid-ACCESS:
  - Stimulus: pull RST_N low while PREADY=0 in ACCESS.
  - Response: PSEL=PENABLE=0 the same cycle, RSP_VALID=0, REQ_READY=1 after release.
